// File: rtl/rx_frame_ctrl.sv
// RX frame sequencer: assembles 5-byte frames (ID, CMD, DATA_L, DATA_H, CHK) and publishes good ones.
// Optional feature macro: RX_CHECKSUM_EN (defined = verify CHK, undefined = accept any well-framed frame).
module rx_frame_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TOWIDTH        = 10
) (
  input  logic        PCLK_rx,
  input  logic        PRESETn_rx,
  input  logic        rx_byte_valid_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_byte_err_i,
  input  logic        read_enable_rx,
  output logic [11:0] reg_receive_rx,
  output logic [7:0]  reg_id_rx,
  output logic [7:0]  reg_command_rx,
  output logic [15:0] reg_data_field_rx,
  output logic [7:0]  reg_status_rx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CMD,
    S_GET_DL,
    S_GET_DH,
    S_GET_CHK
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic [TOWIDTH-1:0] r_to_cnt;
  logic               r_rd_d;
  logic [7:0]         r_sh_id, r_sh_cmd, r_sh_dl, r_sh_dh;
  logic [7:0]         r_id, r_cmd, r_dl, r_dh, r_chk;
  logic [3:0]         r_seq;
  logic               r_ready, r_ovr, r_fe, r_to_flag;

  logic w_consume, w_ok_strobe, w_err_strobe, w_timeout;
  logic w_frame_done, w_chk_ok, w_good, w_cerr_bit;

  assign w_consume    = read_enable_rx & ~r_rd_d;
  assign w_ok_strobe  = rx_byte_valid_i & ~rx_byte_err_i;
  assign w_err_strobe = rx_byte_valid_i & rx_byte_err_i;
  // A strobe on the expiry cycle restarts the counter, so the byte wins over the timeout.
  assign w_timeout    = ~rx_byte_valid_i & (r_state != S_IDLE) &
                        (r_to_cnt == TOWIDTH'(TIMEOUT_CYCLES - 1));
  assign w_frame_done = w_ok_strobe & (r_state == S_GET_CHK);

`ifdef RX_CHECKSUM_EN
  logic [7:0] w_sum;
  logic       r_cerr;
  assign w_sum      = r_sh_id + r_sh_cmd + r_sh_dl + r_sh_dh;
  assign w_chk_ok   = (rx_byte_i == ~w_sum);
  assign w_cerr_bit = r_cerr;

  always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
    if (!PRESETn_rx) r_cerr <= 1'b0;
    else             r_cerr <= (w_frame_done & ~w_chk_ok) | (r_cerr & ~w_consume);
  end
`else
  assign w_chk_ok   = 1'b1;
  assign w_cerr_bit = 1'b0;
`endif

  assign w_good = w_frame_done & w_chk_ok;

  always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
    if (!PRESETn_rx) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_to_cnt <= '0;
      r_rd_d   <= 1'b0;
      r_sh_id  <= '0;
      r_sh_cmd <= '0;
      r_sh_dl  <= '0;
      r_sh_dh  <= '0;
      r_id     <= '0;
      r_cmd    <= '0;
      r_dl     <= '0;
      r_dh     <= '0;
      r_chk    <= '0;
      r_seq    <= '0;
    end else begin
      r_rd_d <= read_enable_rx;

      if (rx_byte_valid_i || (r_state == S_IDLE) || w_timeout) r_to_cnt <= '0;
      else                                                    r_to_cnt <= r_to_cnt + 1'b1;

      if (w_err_strobe || w_timeout) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (w_ok_strobe) begin
        case (r_state)
          S_IDLE: begin
            r_sh_id <= rx_byte_i;
            r_state <= S_GET_CMD;
            r_busy  <= 1'b1;
          end
          S_GET_CMD: begin
            r_sh_cmd <= rx_byte_i;
            r_state  <= S_GET_DL;
            r_busy   <= 1'b1;
          end
          S_GET_DL: begin
            r_sh_dl <= rx_byte_i;
            r_state <= S_GET_DH;
            r_busy  <= 1'b1;
          end
          S_GET_DH: begin
            r_sh_dh <= rx_byte_i;
            r_state <= S_GET_CHK;
            r_busy  <= 1'b1;
          end
          S_GET_CHK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_chk_ok) begin
              r_id  <= r_sh_id;
              r_cmd <= r_sh_cmd;
              r_dl  <= r_sh_dl;
              r_dh  <= r_sh_dh;
              r_chk <= rx_byte_i;
              r_seq <= r_seq + 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky flags: a set on the consume cycle always beats the clear.
  always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
    if (!PRESETn_rx) begin
      r_ready   <= 1'b0;
      r_ovr     <= 1'b0;
      r_fe      <= 1'b0;
      r_to_flag <= 1'b0;
    end else begin
      r_ready   <= w_good | (r_ready & ~w_consume);
      r_ovr     <= (w_good & r_ready & ~w_consume) | (r_ovr & ~w_consume);
      r_fe      <= w_err_strobe | (r_fe & ~w_consume);
      r_to_flag <= w_timeout | (r_to_flag & ~w_consume);
    end
  end

  assign reg_receive_rx    = {r_seq, r_chk};
  assign reg_id_rx         = r_id;
  assign reg_command_rx    = r_cmd;
  assign reg_data_field_rx = {r_dh, r_dl};
  assign reg_status_rx     = {r_busy, 2'b00, r_to_flag, r_fe, r_ovr, w_cerr_bit, r_ready};

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive-side frame sequencer for the RX peripheral. It consumes the byte strobes from the RX byte receiver and assembles 5-byte frames (ID, CMD, DATA_L, DATA_H, CHK). It validates each frame and publishes it into the read-only register set served by the RX APB slave. It also clears frame-ready and sticky error flags when software reads the receive register through that slave.

## Interface
- TIMEOUT_CYCLES, 1024, inter-byte timeout in PCLK_rx cycles while a frame is in progress (≥2)
- TOWIDTH, 10, timeout counter width; 2^TOWIDTH ≥ TIMEOUT_CYCLES
- PCLK_rx  in  1  sole clock, all logic on rising edge
- PRESETn_rx  in  1  asynchronous, active-low reset
- rx_byte_valid_i  in  1  one-cycle strobe, byte available
- rx_byte_i  in  8  received byte, valid with strobe
- rx_byte_err_i  in  1  framing error for the strobed byte
- read_enable_rx  in  1  from APB slave; high during the enable phase of a read at address 5
- reg_receive_rx  out  12  {seq[3:0], chk[7:0]} of last good frame
- reg_id_rx  out  8  ID byte of last good frame
- reg_command_rx  out  8  CMD byte of last good frame
- reg_data_field_rx  out  16  {DATA_H, DATA_L} of last good frame
- reg_status_rx  out  8  bit7 busy, bit4 timeout, bit3 framing err, bit2 overrun, bit1 checksum err, bit0 frame_ready, bits6:5 = 0

## Operation
- FSM states: IDLE, GET_CMD, GET_DL, GET_DH, GET_CHK. Each accepted strobe stores the byte in a shadow register and advances one state; IDLE stores ID.
- Good strobe in GET_CHK: FSM returns to IDLE. If the checksum passes, the shadow ID/CMD/DATA/CHK copy to the output registers, seq increments (4-bit, 15→0 wrap), and frame_ready is set.
- Checksum: CHK == ~(ID+CMD+DL+DH) mod 256. On mismatch, set status[1], leave outputs, seq and frame_ready unchanged, return to IDLE.
- Overrun: a good frame completes while frame_ready=1 → outputs overwritten, status[2] set.
- Framing error: strobe with rx_byte_err_i=1 in any state → byte discarded, status[3] set, FSM to IDLE (partial frame dropped).
- Timeout: counter clears on every strobe and counts while the FSM is not in IDLE. Reaching TIMEOUT_CYCLES-1 → FSM to IDLE, status[4] set.
- Consume: a rising edge of read_enable_rx (registered previous value) clears status[4:0].
- Consume and set in the same cycle: the set wins for every bit. If a good frame completes on the consume cycle, frame_ready stays 1 and overrun is not set.
- busy (status[7]) = 1 whenever the FSM is not IDLE.
- rx_byte_valid_i with no frame pending starts a new frame; there is no sync byte.

## Timing
- All outputs are registered. Reset value of every output: 0. FSM resets to IDLE; seq, shadows, timeout counter and read_enable_rx delay register reset to 0.
- Strobe at edge N → state/busy update visible after edge N+1.
- CHK strobe at edge N → reg_* and status visible after edge N+1. There is no cycle where registers are partially updated.
- Consume: read_enable_rx rises before edge N → flags clear after edge N.
- Back-to-back strobes (every cycle) are accepted without loss.
- Reset assertion mid-frame immediately returns all state to reset values; the partial frame is lost.

## Configuration
- RX_CHECKSUM_EN defined: the checksum is verified as above.
- RX_CHECKSUM_EN undefined:
  - the CHK byte is stored and reported but never compared;
  - every frame with a good framing is accepted;
  - status[1] is tied to 0.

## Test plan
- Good frame: strobes 0x3C,0x12,0x34,0x56,0x27 → reg_id_rx=0x3C, reg_command_rx=0x12, reg_data_field_rx=0x5634, reg_receive_rx=0x127, reg_status_rx=0x01. busy=1 from after the first strobe through the fourth strobe.
- Bad checksum: the same frame with CHK=0x28 → outputs unchanged from reset (all 0), status=0x02 (with RX_CHECKSUM_EN). Repeat without the macro → frame accepted, status=0x01.
- Overrun and consume: two good frames without a read → status=0x05, seq=2. A read_enable_rx pulse → status=0x00. Then a frame completing on the same edge as a consume edge → status=0x01.
- Timeout/framing: 2 strobes, then idle for TIMEOUT_CYCLES cycles → FSM IDLE, status=0x10. Strobe with rx_byte_err_i=1 at GET_DL → status=0x08, busy=0.
- Reset mid-frame: drop PRESETn_rx after 3 strobes → all outputs 0 immediately. A following full good frame is accepted normally with seq=1.
- Seq wrap: 16 good frames → reg_receive_rx[11:8]=0x0.
